// File: rtl/spm_pkg.sv
// spm_pkg: shared types and helpers for the serial-parallel multiplier.
//   spm_state_e : controller states (IDLE waiting for start, RUN stepping the array)
//   spm_cw      : width of the step counter for a given product width
//   spm_ext     : zero/sign extension of an operand of 'width' bits to 128 bits
package spm_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } spm_state_e;

  // Counter must hold values up to pw-1 with one bit of headroom.
  function automatic int unsigned spm_cw(input int unsigned pw);
    return $clog2(pw) + 1;
  endfunction

  // Extends the low 'width' bits of value; bits above width are ignored.
  // Shifts by 64 yield zero, so width=64 produces an all-ones mask.
  function automatic logic [127:0] spm_ext(input logic [63:0] value,
                                           input int unsigned width,
                                           input logic        is_signed);
    logic [63:0] mask_s;
    logic [63:0] low_s;
    logic [63:0] shifted_s;
    logic        sign_s;
    mask_s    = ~({64{1'b1}} << width);
    low_s     = value & mask_s;
    shifted_s = value >> (width - 32'd1);
    sign_s    = is_signed & shifted_s[0];
    if (sign_s) begin
      spm_ext = {{64{1'b1}}, low_s | ~mask_s};
    end else begin
      spm_ext = {64'd0, low_s};
    end
  endfunction

endpackage

// File: rtl/spm_csa_array.sv
// spm_csa_array: shifting carry-save accumulator, one full adder and one
// carry flop per cell. Each step adds (pp_bit ? a_ext : 0) into the saved
// sum/carry state; sums move one cell toward the LSB, carries stay in place
// (their weight drops by one together with the shift).
//   clock, reset : clock and asynchronous active-high reset
//   clear        : treat the stored state as zero for this step (new operation)
//   step_en      : advance the array by one step
//   pp_bit       : current multiplier bit
//   a_ext        : extended multiplicand
//   lsb          : sum leaving cell 0 this step (final product bit)
module spm_csa_array
  import spm_pkg::*;
#(
  parameter int PW = 32
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          step_en,
  input  logic          pp_bit,
  input  logic [PW-1:0] a_ext,
  output logic          lsb
);

  logic [PW-1:0] sum_r;
  logic [PW-1:0] carry_r;
  logic [PW-1:0] sum_in_s;
  logic [PW-1:0] carry_in_s;
  logic [PW-1:0] pp_s;
  logic [PW-1:0] s_s;
  logic [PW-1:0] c_s;

  // Full-adder row over the (optionally cleared) saved state and partial product.
  always_comb begin
    if (clear) begin
      sum_in_s   = {PW{1'b0}};
      carry_in_s = {PW{1'b0}};
    end else begin
      sum_in_s   = sum_r;
      carry_in_s = carry_r;
    end
    if (pp_bit) begin
      pp_s = a_ext;
    end else begin
      pp_s = {PW{1'b0}};
    end
    s_s = sum_in_s ^ carry_in_s ^ pp_s;
    c_s = (sum_in_s & carry_in_s) | (sum_in_s & pp_s) | (carry_in_s & pp_s);
    lsb = s_s[0];
  end

  // Cell state: sums shift toward cell 0, carries from the top cell fall off naturally.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sum_r   <= {PW{1'b0}};
      carry_r <= {PW{1'b0}};
    end else if (step_en) begin
      sum_r   <= {1'b0, s_s[PW-1:1]};
      carry_r <= c_s;
    end else if (clear) begin
      sum_r   <= {PW{1'b0}};
      carry_r <= {PW{1'b0}};
    end else begin
      sum_r   <= sum_r;
      carry_r <= carry_r;
    end
  end

endmodule

// File: rtl/serial_parallel_mult.sv
// serial_parallel_mult: multiplicand held in parallel, multiplier consumed one
// bit per cycle LSB first; product emitted serially LSB first and collected
// into a parallel product register.
//   clock, reset     : clock, asynchronous active-high reset
//   start            : request, accepted when busy=0 (also on the done cycle)
//   signed_mode      : 1 = two's-complement operands, sampled with start
//   a, b             : multiplicand / multiplier, sampled with start
//   busy             : operation in progress (cycles 1..PW-1 after accept)
//   out_valid        : out_bit carries a product bit (cycles 1..PW)
//   out_bit          : serial product bit, LSB first
//   done             : one-cycle pulse with the last product bit
//   product          : full product, updated with done, held otherwise
module serial_parallel_mult
  import spm_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               signed_mode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               out_valid,
  output logic               out_bit,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int PW = 2 * WIDTH;
  localparam int CW = spm_cw(PW);

  spm_state_e    state_r;
  logic [CW-1:0] cnt_r;
  logic [PW-1:0] a_ext_s;
  logic [PW-1:0] b_ext_s;
  logic [PW-1:0] a_ext_r;
  logic [PW-1:0] b_sh_r;
  logic [PW-1:0] a_op_s;
  logic [PW-2:0] shadow_r;
  logic [PW-1:0] product_r;
  logic          accept_s;
  logic          run_s;
  logic          step_s;
  logic          last_s;
  logic          pp_bit_s;
  logic          lsb_s;
  logic          busy_r;
  logic          out_valid_r;
  logic          out_bit_r;
  logic          done_r;

  // Handshake decode and operand selection. Step 0 happens on the accept edge
  // itself, so it feeds the array straight from the freshly extended inputs.
  always_comb begin
    a_ext_s  = PW'(spm_ext(64'(a), WIDTH, signed_mode));
    b_ext_s  = PW'(spm_ext(64'(b), WIDTH, signed_mode));
    accept_s = start && (state_r == ST_IDLE);
    run_s    = (state_r == ST_RUN);
    step_s   = accept_s || run_s;
    last_s   = run_s && (cnt_r == CW'(PW - 1));
    if (accept_s) begin
      a_op_s   = a_ext_s;
      pp_bit_s = b_ext_s[0];
    end else begin
      a_op_s   = a_ext_r;
      pp_bit_s = b_sh_r[0];
    end
  end

  spm_csa_array #(
    .PW (PW)
  ) u_array (
    .clock   (clock),
    .reset   (reset),
    .clear   (accept_s),
    .step_en (step_s),
    .pp_bit  (pp_bit_s),
    .a_ext   (a_op_s),
    .lsb     (lsb_s)
  );

  // Controller, operand latches, step counter and multiplier shift register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
      cnt_r   <= {CW{1'b0}};
      a_ext_r <= {PW{1'b0}};
      b_sh_r  <= {PW{1'b0}};
    end else if (accept_s) begin
      state_r <= ST_RUN;
      busy_r  <= 1'b1;
      cnt_r   <= CW'(1);
      a_ext_r <= a_ext_s;
      b_sh_r  <= b_ext_s >> 1;
    end else if (run_s) begin
      b_sh_r <= b_sh_r >> 1;
      if (last_s) begin
        state_r <= ST_IDLE;
        busy_r  <= 1'b0;
        cnt_r   <= {CW{1'b0}};
      end else begin
        state_r <= ST_RUN;
        busy_r  <= 1'b1;
        cnt_r   <= cnt_r + CW'(1);
      end
    end else begin
      state_r <= state_r;
      busy_r  <= busy_r;
      cnt_r   <= cnt_r;
    end
  end

  // Serial output stage and product collection; the visible product is loaded
  // on the edge that raises done so it appears together with the pulse.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      out_valid_r <= 1'b0;
      out_bit_r   <= 1'b0;
      done_r      <= 1'b0;
      shadow_r    <= {(PW-1){1'b0}};
      product_r   <= {PW{1'b0}};
    end else begin
      out_valid_r <= step_s;
      out_bit_r   <= step_s & lsb_s;
      done_r      <= last_s;
      if (step_s) begin
        shadow_r <= {lsb_s, shadow_r[PW-2:1]};
      end else begin
        shadow_r <= shadow_r;
      end
      if (last_s) begin
        product_r <= {lsb_s, shadow_r};
      end else begin
        product_r <= product_r;
      end
    end
  end

  assign busy      = busy_r;
  assign out_valid = out_valid_r;
  assign out_bit   = out_bit_r;
  assign done      = done_r;
  assign product   = product_r;

endmodule

// File: tb/tb_serial_parallel_mult.sv
module tb_serial_parallel_mult;

  logic        clock;
  logic        rst;
  logic        rst8;
  logic [3:0]  st;
  logic [3:0]  sm;
  logic [15:0] opa [4];
  logic [15:0] opb [4];
  wire  [3:0]  bz_v;
  wire  [3:0]  ov_v;
  wire  [3:0]  ob_v;
  wire  [3:0]  dn_v;
  wire  [3:0]  rst_v;
  wire         rst8_s;
  wire  [31:0] p16;
  wire  [7:0]  p4;
  wire  [15:0] p8;
  wire  [9:0]  p5;

  int          checks;
  int          failures;
  logic [31:0] exp_q [$];
  int          bitcnt [4];
  logic [31:0] ser [4];
  logic [31:0] hold [4];

  assign rst8_s = rst | rst8;
  assign rst_v  = {rst, rst8_s, rst, rst};

  // index 0: WIDTH=16, 1: WIDTH=4, 2: WIDTH=8, 3: WIDTH=5
  serial_parallel_mult #(.WIDTH(16)) dut16 (
    .clock(clock), .reset(rst), .start(st[0]), .signed_mode(sm[0]),
    .a(opa[0]), .b(opb[0]), .busy(bz_v[0]), .out_valid(ov_v[0]),
    .out_bit(ob_v[0]), .done(dn_v[0]), .product(p16));
  serial_parallel_mult #(.WIDTH(4)) dut4 (
    .clock(clock), .reset(rst), .start(st[1]), .signed_mode(sm[1]),
    .a(opa[1][3:0]), .b(opb[1][3:0]), .busy(bz_v[1]), .out_valid(ov_v[1]),
    .out_bit(ob_v[1]), .done(dn_v[1]), .product(p4));
  serial_parallel_mult #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(rst8_s), .start(st[2]), .signed_mode(sm[2]),
    .a(opa[2][7:0]), .b(opb[2][7:0]), .busy(bz_v[2]), .out_valid(ov_v[2]),
    .out_bit(ob_v[2]), .done(dn_v[2]), .product(p8));
  serial_parallel_mult #(.WIDTH(5)) dut5 (
    .clock(clock), .reset(rst), .start(st[3]), .signed_mode(sm[3]),
    .a(opa[3][4:0]), .b(opb[3][4:0]), .busy(bz_v[3]), .out_valid(ov_v[3]),
    .out_bit(ob_v[3]), .done(dn_v[3]), .product(p5));

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog time limit reached checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  function automatic int wid(input int d);
    case (d)
      0:       return 16;
      1:       return 4;
      2:       return 8;
      default: return 5;
    endcase
  endfunction

  function automatic logic [31:0] get_prod(input int d);
    case (d)
      0:       return p16;
      1:       return {24'd0, p4};
      2:       return {16'd0, p8};
      default: return {22'd0, p5};
    endcase
  endfunction

  // Reference: extend to 64 bits, multiply, keep 2*w bits.
  function automatic logic [31:0] ref_prod(input logic [15:0] x, input logic [15:0] y,
                                           input int w, input logic s);
    logic signed [63:0] ex;
    logic signed [63:0] ey;
    logic [63:0]        p;
    logic [63:0]        m;
    m  = (64'd1 << w) - 64'd1;
    ex = {48'd0, x} & m;
    ey = {48'd0, y} & m;
    if (s) begin
      ex = (ex <<< (64 - w)) >>> (64 - w);
      ey = (ey <<< (64 - w)) >>> (64 - w);
    end
    p = ex * ey;
    p = p & ((64'd1 << (2 * w)) - 64'd1);
    return p[31:0];
  endfunction

  // Scoreboard monitor: collects serial bits, compares on done, checks product hold.
  initial begin
    logic [31:0] e;
    logic [31:0] pv;
    for (int d = 0; d < 4; d++) begin
      bitcnt[d] = 0; ser[d] = 32'd0; hold[d] = 32'd0;
    end
    forever begin
      @(negedge clock);
      for (int d = 0; d < 4; d++) begin
        pv = get_prod(d);
        if (rst_v[d]) begin
          bitcnt[d] = 0; ser[d] = 32'd0; hold[d] = 32'd0;
        end else begin
          if (ov_v[d]) begin
            if (bitcnt[d] < 32) ser[d][bitcnt[d]] = ob_v[d];
            bitcnt[d]++;
          end
          if (dn_v[d]) begin
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL unexpected_done dut%0d product=%h", d, pv);
            end else begin
              e = exp_q.pop_front();
              if (pv !== e) begin
                failures++;
                $display("FAIL product dut%0d got=%h exp=%h", d, pv, e);
              end
              checks++;
              if (ser[d] !== e) begin
                failures++;
                $display("FAIL serial_bits dut%0d got=%h exp=%h", d, ser[d], e);
              end
              checks++;
              if (bitcnt[d] != 2 * wid(d)) begin
                failures++;
                $display("FAIL bit_count dut%0d got=%0d exp=%0d", d, bitcnt[d], 2 * wid(d));
              end
            end
            hold[d] = pv; bitcnt[d] = 0; ser[d] = 32'd0;
          end else begin
            checks++;
            if (pv !== hold[d]) begin
              failures++;
              $display("FAIL product_hold dut%0d got=%h exp=%h", d, pv, hold[d]);
            end
          end
        end
      end
    end
  end

  // Issue one operation; returns at the negedge of its done cycle.
  task automatic op(input int d, input logic [15:0] x, input logic [15:0] y,
                    input logic s, input bit noise);
    int n;
    st[d] = 1'b1; opa[d] = x; opb[d] = y; sm[d] = s;
    exp_q.push_back(ref_prod(x, y, wid(d), s));
    @(negedge clock);
    st[d] = 1'b0;
    checks++;
    if (ov_v[d] !== 1'b1 || bz_v[d] !== 1'b1) begin
      failures++;
      $display("FAIL latency dut%0d out_valid=%b busy=%b exp=1/1", d, ov_v[d], bz_v[d]);
    end
    n = 0;
    while (bz_v[d] === 1'b1 && n < 200) begin
      st[d] = noise;
      if (noise) begin
        opa[d] = 16'($urandom); opb[d] = 16'($urandom); sm[d] = 1'($urandom);
      end
      @(negedge clock);
      n++;
    end
    st[d] = 1'b0;
    checks++;
    if (dn_v[d] !== 1'b1 || n != 2 * wid(d) - 1) begin
      failures++;
      $display("FAIL done_align dut%0d done=%b busy_cycles=%0d exp=1/%0d",
               d, dn_v[d], n, 2 * wid(d) - 1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clock);
      checks++;
      if ({bz_v, ov_v, ob_v, dn_v} !== 16'd0 || p16 !== 32'd0 || p4 !== 8'd0 ||
          p8 !== 16'd0 || p5 !== 10'd0) begin
        failures++;
        $display("FAIL reset_outputs flags=%h p16=%h exp=0", {bz_v, ov_v, ob_v, dn_v}, p16);
      end
    end
    rst = 1'b0;
    repeat (5) begin
      @(negedge clock);
      checks++;
      if (bz_v !== 4'd0 || ov_v !== 4'd0 || dn_v !== 4'd0) begin
        failures++;
        $display("FAIL idle_quiet busy=%b out_valid=%b done=%b exp=0", bz_v, ov_v, dn_v);
      end
    end
  endtask

  task automatic test_unsigned();
    op(0, 16'hFFFF, 16'hFFFF, 1'b0, 1'b0);
    @(negedge clock);
    op(0, 16'h0000, 16'h1234, 1'b0, 1'b0);
    @(negedge clock);
    op(0, 16'hABCD, 16'h0000, 1'b1, 1'b0);
    @(negedge clock);
  endtask

  task automatic test_signed();
    op(0, 16'hFFFD, 16'h0007, 1'b1, 1'b0);
    @(negedge clock);
    op(0, 16'h8000, 16'h8000, 1'b1, 1'b0);
    @(negedge clock);
    op(0, 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    op(1, 16'h0005, 16'h0003, 1'b0, 1'b1);
    op(1, 16'h000F, 16'h000F, 1'b0, 1'b1);
    @(negedge clock);
    checks++;
    if (ov_v[1] !== 1'b0 || p4 !== 8'hE1) begin
      failures++;
      $display("FAIL b2b_final out_valid=%b product=%h exp=0/e1", ov_v[1], p4);
    end
  endtask

  task automatic test_reset_mid_run();
    st[2] = 1'b1; opa[2] = 16'h00AA; opb[2] = 16'h0055; sm[2] = 1'b0;
    @(negedge clock);
    st[2] = 1'b0;
    repeat (5) @(negedge clock);
    rst8 = 1'b1;
    #1;
    checks++;
    if (bz_v[2] !== 1'b0 || ov_v[2] !== 1'b0 || ob_v[2] !== 1'b0 || dn_v[2] !== 1'b0 ||
        p8 !== 16'd0) begin
      failures++;
      $display("FAIL mid_reset busy=%b ov=%b ob=%b done=%b product=%h exp=0",
               bz_v[2], ov_v[2], ob_v[2], dn_v[2], p8);
    end
    repeat (2) @(negedge clock);
    rst8 = 1'b0;
    repeat (20) begin
      @(negedge clock);
      checks++;
      if (dn_v[2] !== 1'b0 || ov_v[2] !== 1'b0) begin
        failures++;
        $display("FAIL no_done_after_reset done=%b ov=%b exp=0", dn_v[2], ov_v[2]);
      end
    end
    op(2, 16'h0010, 16'h0010, 1'b0, 1'b0);
    @(negedge clock);
    checks++;
    if (p8 !== 16'h0100) begin
      failures++;
      $display("FAIL post_reset_op product=%h exp=0100", p8);
    end
  endtask

  task automatic test_random(input int d);
    logic [15:0] m;
    m = 16'((32'd1 << wid(d)) - 32'd1);
    for (int i = 0; i < 500; i++) begin
      op(d, 16'($urandom) & m, 16'($urandom) & m, 1'($urandom_range(0, 1)),
         bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) != 0) @(negedge clock);
    end
    @(negedge clock);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; rst8 = 1'b0; st = 4'd0; sm = 4'd0;
    for (int d = 0; d < 4; d++) begin
      opa[d] = 16'd0; opb[d] = 16'd0;
    end
    test_reset();
    test_unsigned();
    test_signed();
    test_back_to_back();
    test_reset_mid_run();
    test_random(3);
    test_random(0);
    @(negedge clock);
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
